// File: rtl/store_buffer.sv
// store_buffer
// Posted-write buffer between the pipeline memory stage and the data memory.
// Stores are queued in a DEPTH-entry FIFO and drained in order. A load is
// accepted only when the buffer is empty and the engine is idle, so it can
// never overtake a buffered store. There is no forwarding.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               pipeline request (valid/write/addr/wdata/sign_mask)
//   req_ready           request accepted when req_valid & req_ready
//   rdata, rdata_valid  load result and its one-cycle qualifier
//   sb_count, sb_empty  occupancy and fully-drained status
//   dm_*                data memory request pins, read data and busy (clk_stall)
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [3:0]                 req_sign_mask,
    output logic                       req_ready,
    output logic [31:0]                rdata,
    output logic                       rdata_valid,
    output logic [$clog2(DEPTH+1)-1:0] sb_count,
    output logic                       sb_empty,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_write_data,
    output logic [3:0]                 dm_sign_mask,
    output logic                       dm_memwrite,
    output logic                       dm_memread,
    input  logic [31:0]                dm_read_data,
    input  logic                       dm_clk_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [31:0]    fifo_addr_r  [DEPTH];
    logic [31:0]    fifo_wdata_r [DEPTH];
    logic [3:0]     fifo_mask_r  [DEPTH];
    logic [PW-1:0]  head_r, tail_r;
    logic [CW-1:0]  count_r, count_s;
    logic           load_pending_r;
    logic [31:0]    load_addr_r;
    logic [3:0]     load_mask_r;
    logic           op_load_r, op_load_s;

    logic           push_s, pop_s, load_acc_s, load_done_s, start_s;
    logic [31:0]    dm_addr_s, dm_write_data_s, rdata_s;
    logic [3:0]     dm_sign_mask_s;
    logic           dm_memwrite_s, dm_memread_s;

    // Request acceptance: depends only on registered state and the request type.
    always_comb begin
        if (req_write) begin
            req_ready = (count_r < CNT_MAX);
        end else begin
            req_ready = (count_r == {CW{1'b0}}) && (state_r == IDLE) && !load_pending_r;
        end
    end

    assign push_s      = req_valid && req_write && req_ready;
    assign load_acc_s  = req_valid && !req_write && req_ready;
    // The transaction retires on the falling edge of the memory's busy flag.
    assign pop_s       = (state_r == WAIT_LO) && !dm_clk_stall && !op_load_r;
    assign load_done_s = (state_r == WAIT_LO) && !dm_clk_stall && op_load_r;
    assign start_s     = (state_r == IDLE) && (state_s == ISSUE);

    // Engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Engine next-state logic; stores take priority over a pending load.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!dm_clk_stall && ((count_r != {CW{1'b0}}) || load_pending_r)) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT_HI;
            WAIT_HI: begin
                if (dm_clk_stall) begin
                    state_s = WAIT_LO;
                end else begin
                    state_s = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!dm_clk_stall) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Engine outputs: next values of the registered memory pins, loaded on
    // entry to ISSUE so the strobes are high exactly while in ISSUE.
    always_comb begin
        dm_addr_s       = dm_addr;
        dm_write_data_s = dm_write_data;
        dm_sign_mask_s  = dm_sign_mask;
        dm_memwrite_s   = 1'b0;
        dm_memread_s    = 1'b0;
        op_load_s       = op_load_r;
        rdata_s         = rdata;
        if (start_s) begin
            if (count_r != {CW{1'b0}}) begin
                dm_addr_s       = fifo_addr_r[head_r];
                dm_write_data_s = fifo_wdata_r[head_r];
                dm_sign_mask_s  = fifo_mask_r[head_r];
                dm_memwrite_s   = 1'b1;
                op_load_s       = 1'b0;
            end else begin
                dm_addr_s       = load_addr_r;
                dm_sign_mask_s  = load_mask_r;
                dm_memread_s    = 1'b1;
                op_load_s       = 1'b1;
            end
        end else begin
            op_load_s = op_load_r;
        end
        if (load_done_s) begin
            rdata_s = dm_read_data;
        end else begin
            rdata_s = rdata;
        end
    end

    // Occupancy next value; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[tail_r]  <= req_addr;
            fifo_wdata_r[tail_r] <= req_wdata;
            fifo_mask_r[tail_r]  <= req_sign_mask;
        end
    end

    // Pointers, occupancy, load register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            load_pending_r <= 1'b0;
            load_addr_r    <= 32'h0000_0000;
            load_mask_r    <= 4'h0;
            op_load_r      <= 1'b0;
            sb_empty       <= 1'b1;
            rdata          <= 32'h0000_0000;
            rdata_valid    <= 1'b0;
            dm_addr        <= 32'h0000_0000;
            dm_write_data  <= 32'h0000_0000;
            dm_sign_mask   <= 4'h0;
            dm_memwrite    <= 1'b0;
            dm_memread     <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (load_acc_s) begin
                load_addr_r    <= req_addr;
                load_mask_r    <= req_sign_mask;
                load_pending_r <= 1'b1;
            end else if (load_done_s) begin
                load_pending_r <= 1'b0;
            end
            count_r       <= count_s;
            op_load_r     <= op_load_s;
            sb_empty      <= (count_s == {CW{1'b0}}) && (state_s == IDLE);
            rdata         <= rdata_s;
            rdata_valid   <= load_done_s;
            dm_addr       <= dm_addr_s;
            dm_write_data <= dm_write_data_s;
            dm_sign_mask  <= dm_sign_mask_s;
            dm_memwrite   <= dm_memwrite_s;
            dm_memread    <= dm_memread_s;
        end
    end

    assign sb_count = count_r;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a behavioural data memory, a reference
// memory image updated in program order, and a scoreboard of expected memory
// writes and load results checked by an independent monitor.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sign_mask;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [2:0]  sb_count;
    logic        sb_empty;
    logic [31:0] dm_addr, dm_write_data, dm_read_data;
    logic [3:0]  dm_sign_mask;
    logic        dm_memwrite, dm_memread, dm_clk_stall;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_sign_mask(req_sign_mask), .req_ready(req_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .sb_count(sb_count), .sb_empty(sb_empty),
        .dm_addr(dm_addr), .dm_write_data(dm_write_data), .dm_sign_mask(dm_sign_mask),
        .dm_memwrite(dm_memwrite), .dm_memread(dm_memread),
        .dm_read_data(dm_read_data), .dm_clk_stall(dm_clk_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          wr_seen = 0;
    logic        prev_mw = 1'b0;
    logic [7:0]  led = 8'h00;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dmem    [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Behavioural data memory: busy for two cycles starting the cycle after a request.
    initial begin
        dm_clk_stall = 1'b0;
        dm_read_data = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && (dm_memwrite || dm_memread)) begin
                if (dm_memwrite) begin
                    dmem[dm_addr] = dm_write_data;
                    if (dm_addr == 32'h0000_2000) led = dm_write_data[7:0];
                end else begin
                    dm_read_data = dmem.exists(dm_addr) ? dmem[dm_addr] : 32'h0;
                end
                @(posedge clk); #1; dm_clk_stall = 1'b1;
                @(posedge clk); #1;
                @(posedge clk); #1; dm_clk_stall = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or a load result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_mw) check("memwrite_pulse", {31'b0, dm_memwrite}, 32'h0);
            if (dm_memwrite || dm_memread) begin
                check("issue_while_stall", {31'b0, dm_clk_stall}, 32'h0);
                check("one_strobe", {31'b0, dm_memwrite & dm_memread}, 32'h0);
            end
            if (dm_memwrite) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", dm_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", dm_addr, e.a);
                    check("wr_data", dm_write_data, e.d);
                    check("wr_mask", {28'b0, dm_sign_mask}, {28'b0, e.m});
                end
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rdata", rdata, ~rdata);
                end else begin
                    check("rdata", rdata, exp_rd.pop_front());
                end
            end
            prev_mw <= dm_memwrite;
        end else begin
            prev_mw <= 1'b0;
        end
    end

    // Present one request from posedge+1; sample readiness on the falling edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int waited);
        bit ok;
        waited = 0;
        ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_sign_mask = m;
        while (!ok) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 300) break;
            end
        end
        if (ok) begin
            acc_cyc = cyc;
            if (w) begin
                exp_wr.push_back('{a: a, d: d, m: m});
                ref_mem[a] = d;
            end else begin
                exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'h0);
            end
        end else begin
            timeout("req_accept");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int waited);
        int n;
        do_req(1'b0, a, 32'h0, 4'h2, waited);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdata_valid && n < 100);
        if (!rdata_valid) timeout("load_result");
        else check("load_latency", cyc - acc_cyc, 32'd6);
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!sb_empty && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sb_empty) timeout("drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, {29'b0, sb_count}, 32'h0);
        check({tag, "_empty"}, {31'b0, sb_empty}, 32'h1);
        check({tag, "_dm_addr"}, dm_addr, 32'h0);
        check({tag, "_dm_wdata"}, dm_write_data, 32'h0);
        check({tag, "_dm_strobes"}, {30'b0, dm_memwrite, dm_memread}, 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_rvalid"}, {31'b0, rdata_valid}, 32'h0);
    endtask

    initial begin
        int w;
        int n;
        int snap;
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_sign_mask = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single store then load back.
        do_req(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0100, w);
        check("single_count_1", {29'b0, sb_count}, 32'h1);
        wait_empty();
        check("single_count_0", {29'b0, sb_count}, 32'h0);
        do_load(32'h0000_1004, w);

        // Five back-to-back stores: the fifth must wait for the first pop.
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, 32'h0000_0300 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, w);
            if (i == 3) check("full_count", {29'b0, sb_count}, 32'd4);
            if (i == 4) check("fifth_waited", {31'b0, (w > 0)}, 32'h1);
        end
        wait_empty();

        // Load behind three buffered stores to the same address.
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 32'h0000_0400, 32'h1111_0000 + 32'(i), 4'hF, w);
        end
        do_load(32'h0000_0400, w);
        check("load_blocked", {31'b0, (w > 0)}, 32'h1);

        // Store to the LED address.
        do_req(1'b1, 32'h0000_2000, 32'h0000_00A5, 4'hF, w);
        wait_empty();
        check("led", {24'b0, led}, 32'h0000_00A5);

        // Push and pop on the same edge at sb_count == 2.
        do_req(1'b1, 32'h0000_0500, 32'h5500_0001, 4'hF, w);
        do_req(1'b1, 32'h0000_0504, 32'h5500_0002, 4'hF, w);
        n = 0;
        while (!(dm_clk_stall == 1'b0 && dut.state_r != 2'd0 && sb_count == 3'd2 && n > 2)
               && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            timeout("pushpop_align");
        end else begin
            do_req(1'b1, 32'h0000_0508, 32'h5500_0003, 4'hF, w);
            check("pushpop_count", {29'b0, sb_count}, 32'd2);
        end
        wait_empty();

        // Randomised traffic over a small address set.
        for (int i = 0; i < 150; i++) begin
            a = 32'h0000_0100 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) begin
                do_load(a, w);
            end else begin
                do_req(1'b1, a, $urandom, 4'($urandom_range(0, 15)), w);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_empty();

        // Reset while the first of three stores is in WAIT_LO.
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 32'h0000_9000 + 32'(i * 4), 32'h9900_0000 + 32'(i), 4'hF, w);
        end
        n = 0;
        while (!dm_clk_stall && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop");
        exp_wr.delete();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap = wr_seen;
        repeat (20) @(posedge clk);
        #1;
        check("no_write_after_reset", wr_seen, snap);

        check("leftover_writes", exp_wr.size(), 32'h0);
        check("leftover_reads", exp_rd.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
